// File: rtl/register_bank_mp.sv
// register_bank_mp
//   Per-lane register file for the SIMT core: NUM_LANES independent columns
//   of NUM_REGS x DATA_W registers. It has two registered read ports and one
//   write port. The address on each port is shared by all lanes, and every
//   lane has its own enable.
//   After reset, a sweep FSM zeroes the storage before the bank reports
//   ready. The same sweep runs again on a bulk-clear request.
//
// Build option:
//   RBANK_BYPASS_EN  defined   -> write-first: a read that hits a same-cycle
//                                 write returns the new data.
//                    undefined -> read-first: the read returns the
//                                 pre-write contents.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   read_en_0/raddr_0   port 0 per-lane read enable, shared read address
//   read_en_1/raddr_1   port 1 per-lane read enable, shared read address
//   write_en/waddr      per-lane write enable, shared write address
//   wdata               write data, lane L at [L*DATA_W +: DATA_W]
//   clr_req             pulse: zero-sweep all registers (honoured in IDLE)
//   rdata_0/rvalid_0    port 0 read data / per-lane valid (1-cycle latency)
//   rdata_1/rvalid_1    port 1 read data / per-lane valid
//   ready               bank accepts reads and writes
//   oob_err             one-cycle pulse: an enabled access used addr >= NUM_REGS

module register_bank_mp #(
  parameter int NUM_LANES = 8,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        read_en_0,
  input  logic [ADDR_W-1:0]           raddr_0,
  input  logic [NUM_LANES-1:0]        read_en_1,
  input  logic [ADDR_W-1:0]           raddr_1,
  input  logic [NUM_LANES-1:0]        write_en,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [NUM_LANES*DATA_W-1:0] wdata,
  input  logic                        clr_req,
  output logic [NUM_LANES*DATA_W-1:0] rdata_0,
  output logic [NUM_LANES-1:0]        rvalid_0,
  output logic [NUM_LANES*DATA_W-1:0] rdata_1,
  output logic [NUM_LANES-1:0]        rvalid_1,
  output logic                        ready,
  output logic                        oob_err
);

`ifdef RBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_IDLE  = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              ready_q;
  logic              idle;

  logic [DATA_W-1:0] mem [NUM_REGS][NUM_LANES];

  // Address range checks. The address is widened by one bit so that the
  // compare also works when NUM_REGS is a power of two.
  logic              raddr_0_ok, raddr_1_ok, waddr_ok;
  logic [ADDR_W-1:0] raddr_0_idx, raddr_1_idx;

  assign raddr_0_ok  = ({1'b0, raddr_0} < REGS_EXT);
  assign raddr_1_ok  = ({1'b0, raddr_1} < REGS_EXT);
  assign waddr_ok    = ({1'b0, waddr}   < REGS_EXT);
  // Out-of-range reads return zero. Clamping the index keeps the array
  // lookup inside its bounds.
  assign raddr_0_idx = raddr_0_ok ? raddr_0 : '0;
  assign raddr_1_idx = raddr_1_ok ? raddr_1 : '0;

  assign idle  = (state == ST_IDLE);
  assign ready = ready_q;

  // Sweep FSM: INIT and CLEAR share the same row-by-row zeroing walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      ptr     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_CLEAR: begin
          if (ptr == LAST_ROW) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            ready_q <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          ptr     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset. Outside IDLE the sweep owns the write port, so
  // writes from the user are dropped. A user write that arrives on the same
  // edge as clr_req is still performed; the sweep overwrites it later.
  always_ff @(posedge clk) begin
    if (!idle) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        mem[ptr][l] <= '0;
      end
    end else if (waddr_ok) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (write_en[l]) begin
          mem[waddr][l] <= wdata[l*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Per-lane read pipelines for both ports.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_W-1:0] wlane;
    logic              hit0, hit1;
    logic [DATA_W-1:0] word0, word1;
    logic [DATA_W-1:0] q0, q1;
    logic              v0, v1;

    assign wlane = wdata[l*DATA_W +: DATA_W];
    assign hit0  = BYPASS && write_en[l] && waddr_ok && (waddr == raddr_0);
    assign hit1  = BYPASS && write_en[l] && waddr_ok && (waddr == raddr_1);

    always_comb begin
      word0 = '0;
      if (raddr_0_ok) begin
        word0 = hit0 ? wlane : mem[raddr_0_idx][l];
      end
    end

    always_comb begin
      word1 = '0;
      if (raddr_1_ok) begin
        word1 = hit1 ? wlane : mem[raddr_1_idx][l];
      end
    end

    // rdata holds its value when the lane is not read; rvalid drops to 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q0 <= '0;
        q1 <= '0;
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else begin
        v0 <= idle && read_en_0[l];
        v1 <= idle && read_en_1[l];
        if (idle && read_en_0[l]) begin
          q0 <= word0;
        end
        if (idle && read_en_1[l]) begin
          q1 <= word1;
        end
      end
    end

    assign rdata_0[l*DATA_W +: DATA_W] = q0;
    assign rdata_1[l*DATA_W +: DATA_W] = q1;
    assign rvalid_0[l]                 = v0;
    assign rvalid_1[l]                 = v1;
  end

  // An access that the bank would drop anyway, because it arrives outside
  // IDLE, does not raise oob_err.
  logic oob_next;

  always_comb begin
    oob_next = idle && (((|read_en_0) && !raddr_0_ok) ||
                        ((|read_en_1) && !raddr_1_ok) ||
                        ((|write_en)  && !waddr_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_err <= 1'b0;
    end else begin
      oob_err <= oob_next;
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
module tb_register_bank_mp;

  localparam int NL  = 8;
  localparam int NR  = 32;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance (32 registers)
  logic [NL-1:0]    read_en_0, read_en_1, write_en;
  logic [AW-1:0]    raddr_0, raddr_1, waddr;
  logic [NL*DW-1:0] wdata;
  logic             clr_req;
  logic [NL*DW-1:0] rdata_0, rdata_1;
  logic [NL-1:0]    rvalid_0, rvalid_1;
  logic             ready, oob_err;

  // Second instance (20 registers), used for out-of-range accesses
  logic [NL-1:0]    s_read_en_0, s_read_en_1, s_write_en;
  logic [AW-1:0]    s_raddr_0, s_raddr_1, s_waddr;
  logic [NL*DW-1:0] s_wdata;
  logic             s_clr_req;
  logic [NL*DW-1:0] s_rdata_0, s_rdata_1;
  logic [NL-1:0]    s_rvalid_0, s_rvalid_1;
  logic             s_ready, s_oob_err;

  register_bank_mp #(.NUM_LANES(NL), .NUM_REGS(NR), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .read_en_0(read_en_0), .raddr_0(raddr_0),
    .read_en_1(read_en_1), .raddr_1(raddr_1),
    .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req),
    .rdata_0(rdata_0), .rvalid_0(rvalid_0),
    .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .ready(ready), .oob_err(oob_err)
  );

  register_bank_mp #(.NUM_LANES(NL), .NUM_REGS(NR2), .DATA_W(DW)) u_dut20 (
    .clk(clk), .rst_n(rst_n),
    .read_en_0(s_read_en_0), .raddr_0(s_raddr_0),
    .read_en_1(s_read_en_1), .raddr_1(s_raddr_1),
    .write_en(s_write_en), .waddr(s_waddr), .wdata(s_wdata),
    .clr_req(s_clr_req),
    .rdata_0(s_rdata_0), .rvalid_0(s_rvalid_0),
    .rdata_1(s_rdata_1), .rvalid_1(s_rvalid_1),
    .ready(s_ready), .oob_err(s_oob_err)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: storage contents, expected outputs, and a count of
  // the sweep edges still to come.
  logic [DW-1:0]    mm [NR][NL];
  logic [NL*DW-1:0] e_rd0, e_rd1;
  logic [NL-1:0]    e_v0, e_v1;
  bit               e_ready;
  int               busy;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a, input int l);
    logic [DW-1:0] w;
    w = wdata[l*DW +: DW];
`ifdef RBANK_BYPASS_EN
    if (write_en[l] && waddr == a) return w;
`endif
    return mm[a][l];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++)
      for (int l = 0; l < NL; l++)
        mm[r][l] = '0;
  endtask

  task automatic idle_inputs();
    read_en_0 = '0; read_en_1 = '0; write_en = '0;
    raddr_0 = '0; raddr_1 = '0; waddr = '0;
    wdata = '0; clr_req = 1'b0;
  endtask

  task automatic rand_wdata();
    for (int l = 0; l < NL; l++) wdata[l*DW +: DW] = $urandom();
  endtask

  // Work out what the spec says should happen on the next edge, advance one
  // clock, then compare every output of the main instance.
  task automatic cycle();
    if (e_ready) begin
      for (int l = 0; l < NL; l++) begin
        if (read_en_0[l]) e_rd0[l*DW +: DW] = peek(raddr_0, l);
        if (read_en_1[l]) e_rd1[l*DW +: DW] = peek(raddr_1, l);
      end
      e_v0 = read_en_0;
      e_v1 = read_en_1;
      for (int l = 0; l < NL; l++)
        if (write_en[l]) mm[waddr][l] = wdata[l*DW +: DW];
      if (clr_req) begin
        e_ready = 1'b0;
        busy    = NR;
        model_clear();
      end
    end else begin
      e_v0 = '0;
      e_v1 = '0;
      busy--;
      if (busy == 0) e_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rdata_0",  256'(rdata_0),  256'(e_rd0));
    chk("rvalid_0", 256'(rvalid_0), 256'(e_v0));
    chk("rdata_1",  256'(rdata_1),  256'(e_rd1));
    chk("rvalid_1", 256'(rvalid_1), 256'(e_v1));
    chk("ready",    256'(ready),    256'(e_ready));
    chk("oob_err",  256'(oob_err),  256'(1'b0));
  endtask

  task automatic model_reset();
    e_rd0 = '0; e_rd1 = '0; e_v0 = '0; e_v1 = '0;
    e_ready = 1'b0;
    busy = NR;
  endtask

  task automatic read_all_both();
    for (int a = 0; a < NR; a++) begin
      idle_inputs();
      read_en_0 = '1; read_en_1 = '1;
      raddr_0 = AW'(a); raddr_1 = AW'(a);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]    old7;
    logic [NL*DW-1:0] exp5;

    rst_n = 1'b0;
    idle_inputs();
    s_read_en_0 = '0; s_read_en_1 = '0; s_write_en = '0;
    s_raddr_0 = '0; s_raddr_1 = '0; s_waddr = '0; s_wdata = '0; s_clr_req = 1'b0;
    model_reset();
    model_clear();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata_0",  256'(rdata_0),  256'(0));
    chk("rst_rvalid_0", 256'(rvalid_0), 256'(0));
    chk("rst_rdata_1",  256'(rdata_1),  256'(0));
    chk("rst_rvalid_1", 256'(rvalid_1), 256'(0));
    chk("rst_ready",    256'(ready),    256'(0));
    chk("rst_oob",      256'(oob_err),  256'(0));
    chk("rst_ready20",  256'(s_ready),  256'(0));

    // INIT sweep: ready rises on the 32nd edge; then every register reads 0
    rst_n = 1'b1;
    repeat (NR) cycle();
    read_all_both();

    // Write each address, then read it on port 0, port 1, and both ports
    for (int a = 0; a < NR; a++) begin
      idle_inputs(); write_en = '1; waddr = AW'(a); rand_wdata(); cycle();
      idle_inputs(); read_en_0 = '1; raddr_0 = AW'(a); cycle();
      idle_inputs(); read_en_1 = '1; raddr_1 = AW'(a); cycle();
      idle_inputs(); read_en_0 = '1; read_en_1 = '1;
      raddr_0 = AW'(a); raddr_1 = AW'(a); cycle();
    end

    // Partial lane mask over a known background
    idle_inputs(); write_en = '1; waddr = 5'd3;
    for (int l = 0; l < NL; l++) wdata[l*DW +: DW] = 32'h1111_1111;
    cycle();
    idle_inputs(); write_en = 8'hA5; waddr = 5'd3; rand_wdata(); cycle();
    idle_inputs(); read_en_0 = '1; raddr_0 = 5'd3; cycle();
    chk("a5_lane1_kept", 256'(rdata_0[63:32]), 256'(32'h1111_1111));
    chk("a5_lane6_kept", 256'(rdata_0[223:192]), 256'(32'h1111_1111));

    // Same-cycle write and read at addr 7
    old7 = mm[7][0];
    idle_inputs(); write_en = '1; waddr = 5'd7; read_en_0 = '1; raddr_0 = 5'd7;
    for (int l = 0; l < NL; l++) wdata[l*DW +: DW] = 32'hDEAD_BEEF;
    cycle();
`ifdef RBANK_BYPASS_EN
    chk("rw_same_cycle", 256'(rdata_0[31:0]), 256'(32'hDEAD_BEEF));
`else
    chk("rw_same_cycle", 256'(rdata_0[31:0]), 256'(old7));
`endif
    idle_inputs(); read_en_0 = '1; raddr_0 = 5'd7; cycle();
    chk("rw_next_read", 256'(rdata_0[31:0]), 256'(32'hDEAD_BEEF));

    // Random traffic
    repeat (300) begin
      idle_inputs();
      read_en_0 = NL'($urandom()); read_en_1 = NL'($urandom());
      write_en  = NL'($urandom());
      raddr_0 = AW'($urandom()); raddr_1 = AW'($urandom());
      waddr   = AW'($urandom());
      rand_wdata();
      cycle();
    end

    // Bulk clear with a same-cycle write; writes and reads during the sweep
    idle_inputs(); clr_req = 1'b1; write_en = '1; waddr = 5'd9; rand_wdata(); cycle();
    repeat (NR) begin
      idle_inputs();
      write_en = '1; waddr = AW'($urandom()); rand_wdata();
      read_en_0 = '1; raddr_0 = AW'($urandom());
      cycle();
    end
    read_all_both();

    // Reset in the middle of a sweep
    idle_inputs(); write_en = '1; waddr = 5'd4; rand_wdata(); wdata[31:0] = 32'hA5A5_0001; cycle();
    idle_inputs(); read_en_0 = '1; read_en_1 = '1; raddr_0 = 5'd4; raddr_1 = 5'd4; cycle();
    idle_inputs(); clr_req = 1'b1; cycle();
    idle_inputs();
    repeat (10) cycle();
    rst_n = 1'b0;
    #2;
    chk("midrst_rdata_0",  256'(rdata_0),  256'(0));
    chk("midrst_rvalid_0", 256'(rvalid_0), 256'(0));
    chk("midrst_rdata_1",  256'(rdata_1),  256'(0));
    chk("midrst_ready",    256'(ready),    256'(0));
    chk("midrst_oob",      256'(oob_err),  256'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (NR) cycle();
    read_all_both();

    // Out-of-range accesses on the 20-register instance
    chk("s_ready", 256'(s_ready), 256'(1));
    s_write_en = '1; s_waddr = 5'd5;
    for (int l = 0; l < NL; l++) s_wdata[l*DW +: DW] = 32'hCAFE_0000 + DW'(l);
    exp5 = s_wdata;
    tick();
    chk("s_oob_inrange", 256'(s_oob_err), 256'(0));
    s_write_en = '1; s_waddr = 5'd25;
    for (int l = 0; l < NL; l++) s_wdata[l*DW +: DW] = 32'h5555_5555;
    s_read_en_0 = '1; s_raddr_0 = 5'd25;
    s_read_en_1 = '1; s_raddr_1 = 5'd5;
    tick();
    chk("s_oob_pulse",   256'(s_oob_err),  256'(1));
    chk("s_oob_rdata",   256'(s_rdata_0),  256'(0));
    chk("s_oob_rvalid",  256'(s_rvalid_0), 256'(8'hFF));
    chk("s_rdata_5",     256'(s_rdata_1),  256'(exp5));
    s_write_en = '0; s_read_en_0 = '0; s_read_en_1 = '0;
    tick();
    chk("s_oob_one_cycle", 256'(s_oob_err), 256'(0));
    s_read_en_0 = '1; s_raddr_0 = 5'd5;
    s_read_en_1 = '1; s_raddr_1 = 5'd19;
    tick();
    chk("s_kept_5",  256'(s_rdata_0), 256'(exp5));
    chk("s_kept_19", 256'(s_rdata_1), 256'(0));
    chk("s_oob_quiet", 256'(s_oob_err), 256'(0));
    s_read_en_0 = '0; s_read_en_1 = 8'h01; s_raddr_1 = 5'd31;
    tick();
    chk("s_oob_port1", 256'(s_oob_err), 256'(1));
    chk("s_oob_port1_valid", 256'(s_rvalid_1), 256'(8'h01));
    s_read_en_1 = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
